// File: rtl/fifo_pkg.sv
// Shared sizing constants for the byte FIFO and its storage array.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH      = 8;
    localparam int unsigned FIFO_ADDR_WIDTH = 3;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// registered read port whose output holds when no read is requested.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A same-address read and write returns the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo.sv
// Single-clock byte FIFO with full/empty decode and a registered one-cycle
// error pulse for a read while empty or a write while full.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  invalid
);

    localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  invalid_q, invalid_d;
    logic                  rd_acc, wr_acc;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // When full, a simultaneous read frees the slot the write lands in.
    always_comb begin
        rd_acc    = read_n & ~empty;
        wr_acc    = write_n & (~full | rd_acc);
        invalid_d = (read_n & empty) | (write_n & full & ~read_n);
        wr_ptr_d  = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d   = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            invalid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            invalid_q <= invalid_d;
        end
    end

    assign invalid = invalid_q;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .reset(reset),
        .we   (wr_acc),
        .waddr(wr_ptr_q),
        .wdata(data_in),
        .re   (rd_acc),
        .raddr(rd_ptr_q),
        .rdata(data_out)
    );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fifo;

    localparam int unsigned Depth = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       read_n = 1'b0;
    logic       write_n = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty, invalid;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] model_q[$];
    logic [7:0] m_dout = '0;
    logic       m_inv = 1'b0;

    always #5 clk = ~clk;

    fifo u_dut (
        .clk     (clk),
        .reset   (reset),
        .read_n  (read_n),
        .write_n (write_n),
        .data_in (data_in),
        .data_out(data_out),
        .full    (full),
        .empty   (empty),
        .invalid (invalid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, update the model from pre-edge occupancy, compare.
    task automatic step(input logic rst, input logic rd, input logic wr, input logic [7:0] din);
        bit was_empty, was_full, rd_ok, wr_ok;
        reset   = rst;
        read_n  = rd;
        write_n = wr;
        data_in = din;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            m_dout = '0;
            m_inv  = 1'b0;
        end else begin
            was_empty = (model_q.size() == 0);
            was_full  = (model_q.size() == Depth);
            m_inv = (rd && was_empty) || (wr && was_full && !rd);
            rd_ok = rd && !was_empty;
            wr_ok = wr && (!was_full || rd_ok);
            if (rd_ok) m_dout = model_q.pop_front();
            if (wr_ok) model_q.push_back(din);
        end
        #1;
        check_eq("data_out", data_out, m_dout);
        check_eq("full", full, model_q.size() == Depth);
        check_eq("empty", empty, model_q.size() == 0);
        check_eq("invalid", invalid, m_inv);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic rd();
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] seq_a[8] = '{8'd13, 8'd4, 8'd5, 8'd8, 8'd2, 8'd9, 8'd1, 8'd5};

    initial begin
        // Reset then read on empty.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_dout", data_out, 0);
        rd();
        check_eq("empty_rd_inv", invalid, 1);
        idle();
        check_eq("inv_one_cycle", invalid, 0);

        // Write 3, 6, read twice, then read on empty.
        wr(8'd3);
        wr(8'd6);
        rd();
        check_eq("rd_first", data_out, 3);
        rd();
        check_eq("rd_second", data_out, 6);
        check_eq("empty_after", empty, 1);
        rd();
        check_eq("hold_on_reject", data_out, 6);

        // Fill, overfill, drain, overdrain.
        foreach (seq_a[i]) wr(seq_a[i]);
        check_eq("full_after_8", full, 1);
        wr(8'd9);
        wr(8'd0);
        wr(8'd6);
        check_eq("wr_full_inv", invalid, 1);
        for (int i = 0; i < 11; i++) rd();
        check_eq("drain_hold", data_out, 5);

        // Wrap-around.
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
        for (int i = 0; i < 5; i++) rd();
        for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
        for (int i = 0; i < 8; i++) rd();
        check_eq("wrap_last", data_out, 8'h87);

        // Simultaneous read/write when full, then drain.
        for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
        step(1'b0, 1'b1, 1'b1, 8'hee);
        check_eq("rw_full_dout", data_out, 8'h10);
        check_eq("rw_full_full", full, 1);
        for (int i = 0; i < 8; i++) rd();
        check_eq("rw_full_last", data_out, 8'hee);

        // Simultaneous read/write when empty.
        step(1'b0, 1'b1, 1'b1, 8'h5a);
        check_eq("rw_empty_inv", invalid, 1);
        check_eq("rw_empty_notempty", empty, 0);
        rd();
        check_eq("rw_empty_data", data_out, 8'h5a);

        // Reset with 4 entries stored.
        for (int i = 0; i < 4; i++) wr(8'(8'hc0 + i));
        step(1'b1, 1'b1, 1'b1, 8'hff);
        check_eq("rst4_empty", empty, 1);
        check_eq("rst4_dout", data_out, 0);
        rd();
        check_eq("rst4_rd_inv", invalid, 1);
        check_eq("rst4_no_stale", data_out, 0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
